dct_ctrl: RTL

DCT_CTRL -- requirements
Module: dct_ctrl

---
 rtl/dct_pkg.sv | 7 +
 rtl/dct_phase_cnt.sv | 29 ++
 rtl/dct_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: state encoding and default block geometry shared by the DCT controller files.
package dct_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMP = 2'd2, DRAIN = 2'd3} state_t;
    localparam int N_SMP_DEF   = 8;
    localparam int N_STG_DEF   = 3;
    localparam int STG_CYC_DEF = 3;
endpackage

// File: rtl/dct_phase_cnt.sv
// dct_phase_cnt: mod-STG_CYC phase counter carrying into a mod-N_STG stage counter.
module dct_phase_cnt #(
    parameter int STG_CYC = 3,
    parameter int N_STG   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] phase,
    output logic [1:0] stg,
    output logic       last
);
    logic wrap;
    assign wrap = phase == 2'(STG_CYC - 1);
    assign last = wrap && stg == 2'(N_STG - 1);
    // Both counters wrap to zero on the final cycle, so they read 0 outside COMP.
    always_ff @(negedge clk or negedge reset)
        if (!reset) begin
            phase <= '0;
            stg   <= '0;
        end else if (clr) begin
            phase <= '0;
            stg   <= '0;
        end else if (en) begin
            phase <= wrap ? '0 : phase + 2'd1;
            if (wrap) stg <= last ? '0 : stg + 2'd1;
        end
endmodule

// File: rtl/dct_ctrl.sv
// dct_ctrl: load/compute/drain sequencer for a block DCT datapath, state updates on falling clk.
// Define DCT_CTRL_STALL_CNT_EN to build the saturating output-backpressure counter.
module dct_ctrl
    import dct_pkg::*;
#(
    parameter int N_SMP   = N_SMP_DEF,
    parameter int N_STG   = N_STG_DEF,
    parameter int STG_CYC = STG_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        ld_en,
    output logic [2:0]  ld_addr,
    output logic        stg_en,
    output logic [1:0]  stg_sel,
    output logic [1:0]  phase,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_addr,
    output logic        busy,
    output logic        done,
    output logic [15:0] stall_cnt
);
    state_t     state;
    logic [2:0] smp_cnt, out_cnt;
    logic       accept, hs, comp_last, last_smp, last_out;

    assign in_ready  = state == IDLE || state == LOAD;
    assign accept    = in_valid && in_ready && !flush;
    assign ld_en     = accept;
    assign ld_addr   = smp_cnt;
    assign stg_en    = state == COMP;
    assign out_valid = state == DRAIN;
    assign out_addr  = out_cnt;
    assign busy      = state != IDLE;
    assign hs        = out_valid && out_ready && !flush;
    assign last_smp  = smp_cnt == 3'(N_SMP - 1);
    assign last_out  = out_cnt == 3'(N_SMP - 1);

    dct_phase_cnt #(.STG_CYC(STG_CYC), .N_STG(N_STG)) u_phase (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (stg_en),
        .phase (phase),
        .stg   (stg_sel),
        .last  (comp_last)
    );

    always_ff @(negedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            smp_cnt <= '0;
            out_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= hs && last_out;
            if (flush) begin
                state   <= IDLE;
                smp_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (accept) smp_cnt <= last_smp ? '0 : smp_cnt + 3'd1;
                if (hs) out_cnt <= last_out ? '0 : out_cnt + 3'd1;
                if (accept) state <= last_smp ? COMP : LOAD;
                else if (stg_en && comp_last) state <= DRAIN;
                else if (hs && last_out) state <= IDLE;
            end
        end

`ifdef DCT_CTRL_STALL_CNT_EN
    always_ff @(negedge clk or negedge reset)
        if (!reset) stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`else
    assign stall_cnt = '0;
`endif
endmodule
